// File: rtl/csr_regs_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus field masks and reset
// values, plus helpers describing which addresses accept writes and how write
// data is masked before it lands in a register.
package csr_regs_pkg;

    localparam logic [11:0] INST_CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] INST_CSR_MISA     = 12'h301;
    localparam logic [11:0] INST_CSR_MIE      = 12'h304;
    localparam logic [11:0] INST_CSR_MTVEC    = 12'h305;
    localparam logic [11:0] INST_CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] INST_CSR_MEPC     = 12'h341;
    localparam logic [11:0] INST_CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] INST_CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] INST_CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] INST_CSR_MHARTID  = 12'hF14;

    // Only MIE (bit 3) and MPIE (bit 7) are software-visible state.
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
    // MPP is hardwired to machine mode.
    localparam logic [63:0] MSTATUS_MPP   = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;
    localparam int unsigned MSTATUS_MIE_BIT = 3;

    // True for addresses whose register can be written.
    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            INST_CSR_MSTATUS, INST_CSR_MIE, INST_CSR_MTVEC, INST_CSR_MSCRATCH,
            INST_CSR_MEPC, INST_CSR_MCAUSE, INST_CSR_MCYCLE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Value the register will hold after a write of data to addr.
    function automatic logic [63:0] csr_wmask(input logic [11:0] addr,
                                              input logic [63:0] data);
        case (addr)
            INST_CSR_MSTATUS: return (data & MSTATUS_WMASK) | MSTATUS_MPP;
            INST_CSR_MTVEC,
            INST_CSR_MEPC:    return {data[63:2], 2'b00};
            default:          return data;
        endcase
    endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// 64-bit free-running cycle counter with synchronous load.
//   clk, rst     : clock, synchronous active-high reset (clears to 0)
//   en_i         : load load_val_i this edge instead of incrementing
//   load_val_i   : value to load
//   count_o      : current counter value (wraps naturally at 2^64)
module csr_cycle_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [63:0] load_val_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = en_i ? load_val_i : count_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_regs.sv
// Machine-mode CSR register file. Serves ex reads/writes and clint trap/mret
// writes; exports mtvec/mepc/mstatus and the global interrupt enable to clint.
//   clk, rst                          : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i              : ex write port
//   raddr_i/rdata_o                   : ex combinational read port
//   clint_we_i/clint_waddr_i/_wdata_i : clint write port (wins over ex)
//   clint_raddr_i/clint_rdata_o       : clint combinational read port
//   csr_mtvec_o/csr_mepc_o/csr_mstatus_o, global_int_en_o : register contents
// Only address bits [11:0] are decoded.
module csr_regs
    import csr_regs_pkg::*;
#(
    parameter logic [63:0] MHARTID    = 64'd0,
    parameter logic [63:0] MISA_VALUE = 64'h8000_0000_0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [63:0] waddr_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] raddr_i,
    output logic [63:0] rdata_o,
    input  logic        clint_we_i,
    input  logic [63:0] clint_waddr_i,
    input  logic [63:0] clint_wdata_i,
    input  logic [63:0] clint_raddr_i,
    output logic [63:0] clint_rdata_o,
    output logic [63:0] csr_mtvec_o,
    output logic [63:0] csr_mepc_o,
    output logic [63:0] csr_mstatus_o,
    output logic        global_int_en_o
);

    logic [63:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] mcycle;

    logic        w_en;
    logic [11:0] w_addr;
    logic [63:0] w_data;
    logic [63:0] w_data_m;
    logic        w_hit;

    logic [11:0] rd_addr [2];
    logic [63:0] rd_data [2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr_i[63:12], clint_waddr_i[63:12],
                                raddr_i[63:12], clint_raddr_i[63:12]};

    // clint writes win: the pipeline is stalled then, so a same-cycle ex write is stale.
    always_comb begin
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        if (clint_we_i) begin
            w_en   = 1'b1;
            w_addr = clint_waddr_i[11:0];
            w_data = clint_wdata_i;
        end else if (we_i) begin
            w_en   = 1'b1;
            w_addr = waddr_i[11:0];
            w_data = wdata_i;
        end
    end

    assign w_data_m = csr_wmask(w_addr, w_data);
    assign w_hit    = w_en && csr_writable(w_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (w_hit) begin
            case (w_addr)
                INST_CSR_MSTATUS:  mstatus_q  <= w_data_m;
                INST_CSR_MIE:      mie_q      <= w_data_m;
                INST_CSR_MTVEC:    mtvec_q    <= w_data_m;
                INST_CSR_MSCRATCH: mscratch_q <= w_data_m;
                INST_CSR_MEPC:     mepc_q     <= w_data_m;
                INST_CSR_MCAUSE:   mcause_q   <= w_data_m;
                default: ;
            endcase
        end
    end

    csr_cycle_counter u_cycle_counter (
        .clk        (clk),
        .rst        (rst),
        .en_i       (w_hit && (w_addr == INST_CSR_MCYCLE)),
        .load_val_i (w_data_m),
        .count_o    (mcycle)
    );

    assign rd_addr[0] = raddr_i[11:0];
    assign rd_addr[1] = clint_raddr_i[11:0];

    // Both read ports see the winning write in the same cycle it is issued.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            case (rd_addr[p])
                INST_CSR_MSTATUS:  rd_data[p] = mstatus_q;
                INST_CSR_MISA:     rd_data[p] = MISA_VALUE;
                INST_CSR_MIE:      rd_data[p] = mie_q;
                INST_CSR_MTVEC:    rd_data[p] = mtvec_q;
                INST_CSR_MSCRATCH: rd_data[p] = mscratch_q;
                INST_CSR_MEPC:     rd_data[p] = mepc_q;
                INST_CSR_MCAUSE:   rd_data[p] = mcause_q;
                INST_CSR_MCYCLE,
                INST_CSR_CYCLE:    rd_data[p] = mcycle;
                INST_CSR_MHARTID:  rd_data[p] = MHARTID;
                default:           rd_data[p] = '0;
            endcase
            if (w_hit && (w_addr == rd_addr[p])) begin
                rd_data[p] = w_data_m;
            end
        end
    end

    assign rdata_o         = rd_data[0];
    assign clint_rdata_o   = rd_data[1];
    assign csr_mtvec_o     = mtvec_q;
    assign csr_mepc_o      = mepc_q;
    assign csr_mstatus_o   = mstatus_q;
    assign global_int_en_o = mstatus_q[MSTATUS_MIE_BIT];

endmodule

// File: tb/tb_csr_regs.sv
// Directed bench for csr_regs. Stimulus drives inputs just after posedge and pushes
// expected values; the monitor pops and compares everything queued at the negedge.
module tb_csr_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [63:0] waddr_i, wdata_i, raddr_i, rdata_o;
    logic        clint_we_i;
    logic [63:0] clint_waddr_i, clint_wdata_i, clint_raddr_i, clint_rdata_o;
    logic [63:0] csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
    logic        global_int_en_o;

    localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

    always #5 clk = ~clk;

    csr_regs #(
        .MHARTID    (64'd0),
        .MISA_VALUE (MISA)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .we_i            (we_i),
        .waddr_i         (waddr_i),
        .wdata_i         (wdata_i),
        .raddr_i         (raddr_i),
        .rdata_o         (rdata_o),
        .clint_we_i      (clint_we_i),
        .clint_waddr_i   (clint_waddr_i),
        .clint_wdata_i   (clint_wdata_i),
        .clint_raddr_i   (clint_raddr_i),
        .clint_rdata_o   (clint_rdata_o),
        .csr_mtvec_o     (csr_mtvec_o),
        .csr_mepc_o      (csr_mepc_o),
        .csr_mstatus_o   (csr_mstatus_o),
        .global_int_en_o (global_int_en_o)
    );

    // Which output an expectation refers to.
    localparam int SEL_RDATA = 0, SEL_CRDATA = 1, SEL_MTVEC = 2, SEL_MEPC = 3,
                   SEL_MSTATUS = 4, SEL_GIE = 5;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic expect_val(input int sel, input logic [63:0] v, input string name);
        sb_entry_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_entry_t e;
            logic [63:0] act;
            e = sb.pop_front();
            case (e.sel)
                SEL_RDATA:   act = rdata_o;
                SEL_CRDATA:  act = clint_rdata_o;
                SEL_MTVEC:   act = csr_mtvec_o;
                SEL_MEPC:    act = csr_mepc_o;
                SEL_MSTATUS: act = csr_mstatus_o;
                default:     act = {63'd0, global_int_en_o};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        we_i       = 1'b0;
        clint_we_i = 1'b0;
    endtask

    task automatic ex_wr(input logic [63:0] a, input logic [63:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
    endtask

    task automatic cl_wr(input logic [63:0] a, input logic [63:0] d);
        clint_we_i = 1'b1; clint_waddr_i = a; clint_wdata_i = d;
    endtask

    initial begin
        rst = 1'b1;
        we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        clint_we_i = 1'b0; clint_waddr_i = '0; clint_wdata_i = '0; clint_raddr_i = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state (counter still 0 before the first free-running edge).
        raddr_i = 64'hB00; clint_raddr_i = 64'h301;
        expect_val(SEL_RDATA, 64'd0, "rst_mcycle");
        expect_val(SEL_CRDATA, MISA, "rst_misa");
        expect_val(SEL_MSTATUS, 64'h1800, "rst_mstatus");
        expect_val(SEL_MTVEC, 64'd0, "rst_mtvec");
        expect_val(SEL_MEPC, 64'd0, "rst_mepc");
        expect_val(SEL_GIE, 64'd0, "rst_gie");
        step();
        raddr_i = 64'hF14; clint_raddr_i = 64'hC00;
        expect_val(SEL_RDATA, 64'd0, "rst_mhartid");
        expect_val(SEL_CRDATA, 64'd1, "first_cycle_alias");

        // ex mtvec write with forwarding.
        step();
        ex_wr(64'h305, 64'h8000_0103);
        raddr_i = 64'h305; clint_raddr_i = 64'h305;
        expect_val(SEL_RDATA, 64'h8000_0100, "mtvec_fwd_ex");
        expect_val(SEL_CRDATA, 64'h8000_0100, "mtvec_fwd_clint");
        expect_val(SEL_MTVEC, 64'd0, "mtvec_not_fwd");

        // clint beats ex on same-cycle mepc writes.
        step();
        expect_val(SEL_MTVEC, 64'h8000_0100, "mtvec_out");
        cl_wr(64'h341, 64'h1000);
        ex_wr(64'h341, 64'h2000);
        raddr_i = 64'h341;
        expect_val(SEL_RDATA, 64'h1000, "mepc_arb_fwd");
        expect_val(SEL_MEPC, 64'd0, "mepc_not_fwd");
        step();
        expect_val(SEL_MEPC, 64'h1000, "mepc_arb");
        expect_val(SEL_RDATA, 64'h1000, "mepc_read");

        // mstatus masking and MIE export.
        step();
        cl_wr(64'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        clint_raddr_i = 64'h300;
        expect_val(SEL_CRDATA, 64'h1888, "mstatus_fwd_ones");
        expect_val(SEL_GIE, 64'd0, "gie_not_fwd");
        step();
        expect_val(SEL_MSTATUS, 64'h1888, "mstatus_ones");
        expect_val(SEL_GIE, 64'd1, "gie_set");
        cl_wr(64'h300, 64'h0);
        expect_val(SEL_CRDATA, 64'h1800, "mstatus_fwd_zero");
        step();
        expect_val(SEL_MSTATUS, 64'h1800, "mstatus_zero");
        expect_val(SEL_GIE, 64'd0, "gie_clr");
        ex_wr(64'h341, 64'h2007);
        step();
        expect_val(SEL_MEPC, 64'h2004, "mepc_align");

        // mcycle load, wrap, alias, ignored alias write.
        ex_wr(64'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
        raddr_i = 64'hB00; clint_raddr_i = 64'h0;
        expect_val(SEL_RDATA, 64'hFFFF_FFFF_FFFF_FFFE, "mcycle_fwd");
        step();
        ex_wr(64'hC00, 64'h5);
        clint_raddr_i = 64'hB00;
        expect_val(SEL_RDATA, 64'hFFFF_FFFF_FFFF_FFFE, "mcycle_load");
        expect_val(SEL_CRDATA, 64'hFFFF_FFFF_FFFF_FFFE, "mcycle_load_c");
        step();
        clint_raddr_i = 64'hC00;
        expect_val(SEL_RDATA, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_max");
        expect_val(SEL_CRDATA, 64'hFFFF_FFFF_FFFF_FFFF, "cycle_max");
        step();
        expect_val(SEL_RDATA, 64'd0, "mcycle_wrap");
        expect_val(SEL_CRDATA, 64'd0, "cycle_wrap");
        step();
        expect_val(SEL_RDATA, 64'd1, "mcycle_after_wrap");
        expect_val(SEL_CRDATA, 64'd1, "cycle_after_wrap");

        // Unimplemented address and upper-bit aliasing.
        ex_wr(64'h7C0, 64'hDEAD);
        step();
        raddr_i = 64'h7C0;
        expect_val(SEL_RDATA, 64'd0, "unimpl_read");
        ex_wr(64'hABC_0342, 64'h5);
        step();
        raddr_i = 64'hABC_0342; clint_raddr_i = 64'h342;
        expect_val(SEL_RDATA, 64'h5, "mcause_upper_rd");
        expect_val(SEL_CRDATA, 64'h5, "mcause_upper");

        // Reset during a clint trap write: the write is lost.
        step();
        rst = 1'b1;
        cl_wr(64'h341, 64'h4000);
        step();
        rst = 1'b0;
        raddr_i = 64'hB00; clint_raddr_i = 64'h342;
        expect_val(SEL_MEPC, 64'd0, "rst_mid_trap_mepc");
        expect_val(SEL_MSTATUS, 64'h1800, "rst2_mstatus");
        expect_val(SEL_RDATA, 64'd0, "rst2_mcycle");
        expect_val(SEL_CRDATA, 64'd0, "rst2_mcause");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_regs.md
Name: csr_regs

Overview:
- Machine-mode CSR register file for the RV64 core.
- Serves CSR reads and writes from ex, and the interrupt controller's (clint) CSR writes for trap entry and mret.
- Exports mtvec/mepc/mstatus and the global interrupt enable to clint.
- Sits directly beside clint: it consumes clint's we/waddr/data and produces clint's data_i, csr_mtvec, csr_mepc, csr_mstatus and global_int_en_i.

Parameters:
- MHARTID, 64'd0, value returned for mhartid (0xF14).
- MISA_VALUE, 64'h8000_0000_0000_0100, value returned for misa (0x301): RV64I.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- we_i  in  1  ex CSR write enable
- waddr_i  in  64  ex CSR write address
- wdata_i  in  64  ex CSR write data
- raddr_i  in  64  ex CSR read address
- rdata_o  out  64  ex CSR read data (combinational)
- clint_we_i  in  1  clint CSR write enable
- clint_waddr_i  in  64  clint CSR write address
- clint_wdata_i  in  64  clint CSR write data
- clint_raddr_i  in  64  clint CSR read address
- clint_rdata_o  out  64  clint CSR read data (combinational)
- csr_mtvec_o  out  64  current mtvec register value
- csr_mepc_o  out  64  current mepc register value
- csr_mstatus_o  out  64  current mstatus register value
- global_int_en_o  out  1  mstatus.MIE (bit 3)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on posedge clk.
- Address decode uses bits [11:0] only; bits [63:12] are ignored.
- Implemented CSRs and reset values:
  - mstatus 0x300, reset 64'h1800: MPP=2'b11, MIE=0, MPIE=0.
  - misa 0x301, read-only (MISA_VALUE).
  - mie 0x304, reset 0.
  - mtvec 0x305, reset 0.
  - mscratch 0x340, reset 0.
  - mepc 0x341, reset 0.
  - mcause 0x342, reset 0.
  - mcycle 0xB00, reset 0.
  - cycle 0xC00, read-only alias of mcycle.
  - mhartid 0xF14, read-only (MHARTID).
- Write masks:
  - mstatus: only bits 3 and 7 writable; bits [12:11] always read 2'b11; all other bits read 0.
  - mtvec: bits [1:0] forced 0 (direct mode).
  - mepc: bits [1:0] forced 0.
  - mie, mscratch, mcause, mcycle: all 64 bits writable.
  - Writes to read-only or unimplemented addresses are ignored.
  - Reads of unimplemented addresses return 0.
- Write arbitration:
  - If clint_we_i=1, the clint write is performed and any ex write in that cycle is discarded. The pipeline is held during clint writes, so an ex write in that cycle is stale.
  - Otherwise, if we_i=1, the ex write is performed.
  - Exactly one write per cycle, at most.
- Read forwarding:
  - Applies to both rdata_o and clint_rdata_o.
  - If the winning write this cycle targets the same [11:0] address as the read, the read returns the masked write data.
  - Otherwise the read returns the register value.
  - csr_mtvec_o, csr_mepc_o, csr_mstatus_o and global_int_en_o are NOT forwarded; they reflect register contents. A write becomes visible on them the cycle after the write edge.
- mcycle:
  - Increments by 1 every cycle when not in reset.
  - Wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - A winning write to 0xB00 loads the write data at that edge and suppresses that cycle's increment; it counts up from the loaded value on the next cycle.
- Reset:
  - Applies at the edge with rst=1, including mid-sequence of a clint trap write (the pending write is lost).
  - Outputs after reset: csr_mstatus_o=64'h1800, csr_mtvec_o=0, csr_mepc_o=0, global_int_en_o=0, mcycle=0.
  - rdata_o and clint_rdata_o follow the reset register values.
- Latency:
  - Write: 1 cycle, register updated at the next edge.
  - Read: 0 cycles, combinational.

Decomposition:
- CSR address constants go into the shared defines file alongside the existing CSR definitions: INST_CSR_MSTATUS, MISA, MIE, MTVEC, MSCRATCH, MEPC, MCAUSE, MCYCLE, CYCLE, MHARTID.
- mstatus write mask, MPP constant and reset values also go into the shared defines file.
- One sub-module is natural: csr_cycle_counter. It holds the 64-bit counter with load (en, load_val) and wrap. Everything else stays in csr_regs.

Test Plan:
- Reset with rst=1 for 2 cycles -> csr_mstatus_o=64'h1800, csr_mtvec_o=0, global_int_en_o=0, read 0xF14=MHARTID, read 0x301=64'h8000_0000_0000_0100.
- ex writes mtvec=64'h8000_0103 -> next cycle csr_mtvec_o=64'h8000_0100. Same-cycle rdata_o at raddr 0x305 returns 64'h8000_0100 (forwarding).
- Same cycle: clint writes mepc=64'h1000 and ex writes mepc=64'h2000 -> mepc=64'h1000; ex write discarded.
- clint writes mstatus=64'hFFFF_FFFF_FFFF_FFFF -> csr_mstatus_o=64'h1888, global_int_en_o=1. Then clint writes 64'h0 -> 64'h1800, global_int_en_o=0.
- ex writes mcycle=64'hFFFF_FFFF_FFFF_FFFE -> reads over the following cycles return ...FFFE, ...FFFF, 0, 1. Cycle alias 0xC00 returns the same values; a write to 0xC00 is ignored.
- Write to 0x7C0 then read 0x7C0 -> 0. Upper-address write 64'hABC_0342 with data 5 -> mcause=5.
